// File: rtl/uba_intr_pkg.sv
// Shared types and defaults for the UBA interrupt arbiter.
// The vector-read timeout is optional (UBA_TIMEOUT_EN), see uba_intr_arb.
package uba_intr_pkg;

    localparam int unsigned VECTW       = 16;
    localparam int unsigned SELW        = 3;
    localparam int unsigned TIMEOUT_DEF = 127;
    localparam int unsigned HOLDOFF_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        IACK,
        VECTRD,
        VECTCLR,
        DONE,
        HOLD
    } intrState_t;

endpackage

// File: rtl/uba_intr_prio.sv
// Fixed-priority encoder: lowest asserted request index wins.
module uba_intr_prio
    import uba_intr_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]    req,
    output logic [SELW-1:0] idx,
    output logic            any
);

    always_comb begin
        idx = '0;
        any = |req;
        // Scan downwards so the lowest set bit is written last.
        for (int unsigned i = N; i > 0; i--) begin
            if (req[i-1]) idx = SELW'(i - 1);
        end
    end

endmodule

// File: rtl/uba_intr_arb.sv
// Bus-side interrupt arbiter and vector fetch controller.
// Define UBA_TIMEOUT_EN to build the vector-read timeout counter.
module uba_intr_arb
    import uba_intr_pkg::*;
#(
    parameter int unsigned NDEV    = 4,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned HOLDOFF = HOLDOFF_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NDEV-1:0]       devINTR,
    output logic [NDEV-1:0]       devIACK,
    output logic [NDEV-1:0]       devVECTREAD,
    input  logic [NDEV-1:0]       devVECTACK,
    input  logic [VECTW*NDEV-1:0] devVECT,
    output logic                  cpuINTR,
    input  logic                  cpuIACK,
    output logic [VECTW-1:0]      cpuVECT,
    output logic                  cpuVALID,
    output logic                  cpuNXM
);

    intrState_t         state, nextState;
    logic [SELW-1:0]    sel, nextSel, prioIdx;
    logic               anyReq;
    logic [3:0]         holdCnt, nextHoldCnt;
    logic [VECTW-1:0]   nextVect;
    logic               nextNxm;
    logic [7:0]         nextOneHot;
    logic               toExpired;

    // Pad to eight slots so a 3-bit select indexes cleanly for any NDEV.
    logic [7:0]         ackPad;
    logic [8*VECTW-1:0] vectPad;

    assign ackPad  = 8'(devVECTACK);
    assign vectPad = (8*VECTW)'(devVECT);

    uba_intr_prio #(.N(NDEV)) prio (
        .req (devINTR),
        .idx (prioIdx),
        .any (anyReq)
    );

`ifdef UBA_TIMEOUT_EN
    logic [7:0] toCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 toCnt <= '0;
        else if (state == VECTRD) toCnt <= toCnt + 8'd1;
        else                      toCnt <= '0;
    end

    assign toExpired = (toCnt == 8'(TIMEOUT - 1));
`else
    logic unusedTimeout;

    assign unusedTimeout = ^8'(TIMEOUT);
    assign toExpired     = 1'b0;
`endif

    always_comb begin
        nextState   = state;
        nextSel     = sel;
        nextHoldCnt = holdCnt;
        nextVect    = cpuVECT;
        nextNxm     = cpuNXM;
        case (state)
            IDLE: if (anyReq) nextState = REQ;
            REQ: begin
                if (cpuIACK && anyReq) begin
                    nextSel   = prioIdx;
                    nextState = IACK;
                end else if (cpuIACK) begin
                    nextVect  = '0;
                    nextNxm   = 1'b1;
                    nextState = DONE;
                end else if (!anyReq) begin
                    nextState = IDLE;
                end
            end
            IACK: nextState = VECTRD;
            VECTRD: begin
                if (ackPad[sel]) begin
                    nextVect  = vectPad[{sel, 4'b0000} +: VECTW];
                    nextNxm   = 1'b0;
                    nextState = VECTCLR;
                end else if (toExpired) begin
                    nextVect  = '0;
                    nextNxm   = 1'b1;
                    nextState = DONE;
                end
            end
            VECTCLR: if (!ackPad[sel]) nextState = DONE;
            DONE: begin
                nextHoldCnt = '0;
                nextState   = HOLD;
            end
            HOLD: begin
                if (holdCnt == 4'(HOLDOFF - 1)) nextState = IDLE;
                else                            nextHoldCnt = holdCnt + 4'd1;
            end
            default: nextState = IDLE;
        endcase
        nextOneHot = 8'd1 << nextSel;
    end

    // Outputs are decoded from the next state so they are registered Moore outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            sel         <= '0;
            holdCnt     <= '0;
            cpuINTR     <= 1'b0;
            cpuVALID    <= 1'b0;
            cpuVECT     <= '0;
            cpuNXM      <= 1'b0;
            devIACK     <= '0;
            devVECTREAD <= '0;
        end else begin
            state       <= nextState;
            sel         <= nextSel;
            holdCnt     <= nextHoldCnt;
            cpuVECT     <= nextVect;
            cpuNXM      <= nextNxm;
            cpuINTR     <= (nextState == REQ);
            cpuVALID    <= (nextState == DONE);
            devIACK     <= (nextState == IACK)   ? nextOneHot[NDEV-1:0] : '0;
            devVECTREAD <= (nextState == VECTRD) ? nextOneHot[NDEV-1:0] : '0;
        end
    end

endmodule

// File: doc/uba_intr_arb.md
# uba_intr_arb

Bus-side interrupt arbiter and vector fetch controller for the IO bus adapter; it is the initiator end of the device interrupt handshake. It collects level interrupt requests from up to eight IO devices (DZ11, RH11, LP20, ...) and raises a single request to the CPU-side logic. On CPU acknowledge it selects the highest-priority device, pulses that device's acknowledge, and runs the vector read handshake. It then returns the captured vector, or a non-existent-device flag, to the CPU side.

## Interface
- NDEV, 4, number of device slots (1..8); slot 0 is highest priority.
- TIMEOUT, 127, vector-read timeout in clock cycles (1..255); used only with the timeout feature.
- HOLDOFF, 4, cycles after a completed cycle before requests are resampled (1..15).
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- devINTR  in  NDEV  level interrupt request, one bit per device
- devIACK  out  NDEV  one-hot acknowledge, one-cycle pulse
- devVECTREAD  out  NDEV  one-hot vector read strobe, held until the device acknowledges
- devVECTACK  in  NDEV  device has driven its vector
- devVECT  in  16*NDEV  packed vectors; slot i occupies bits [16i+15:16i]
- cpuINTR  out  1  interrupt request to the CPU side
- cpuIACK  in  1  CPU acknowledge, one-cycle pulse
- cpuVECT  out  16  captured vector
- cpuVALID  out  1  one-cycle pulse: cpuVECT and cpuNXM are valid
- cpuNXM  out  1  no device responded (passive release or timeout)

## Operation
- States: IDLE, REQ, IACK, VECTRD, VECTCLR, DONE, HOLD.
- IDLE: if any devINTR bit is set, go to REQ.
- REQ: cpuINTR=1.
  - If all devINTR bits drop before cpuIACK, return to IDLE.
  - On cpuIACK, latch sel = lowest asserted devINTR index, then go to IACK.
  - If cpuIACK arrives with no devINTR bit set (same-cycle withdrawal), this is a passive release: cpuVECT=0, cpuNXM=1, go to DONE.
- IACK: devIACK[sel]=1 for exactly one cycle, then go to VECTRD.
- VECTRD: devVECTREAD[sel]=1.
  - On devVECTACK[sel], capture the devVECT slice for sel into cpuVECT, clear cpuNXM, and go to VECTCLR.
  - devVECTACK bits of unselected slots are ignored.
- VECTCLR: devVECTREAD=0. Wait for devVECTACK[sel]=0, then go to DONE.
- DONE: cpuVALID=1 for one cycle, then go to HOLD.
- HOLD: count HOLDOFF cycles, then go to IDLE. This lets the serviced device retract devINTR.
- cpuIACK is ignored in every state except REQ.
- cpuVECT and cpuNXM hold their values until the next capture.
- Reset, including mid-cycle: state=IDLE. All outputs are 0: cpuINTR, cpuVECT, cpuVALID, cpuNXM, devIACK, devVECTREAD. sel=0 and all counters=0.

## Timing
- devINTR rising in IDLE gives cpuINTR=1 on the next cycle. All outputs are registered (Moore outputs).
- cpuIACK at cycle t gives devIACK[sel] at t+1 and devVECTREAD[sel] from t+2.
- devVECTACK sampled at cycle u drops devVECTREAD at u+1; cpuVECT is updated at u+1.
- cpuVALID asserts one cycle after VECTCLR observes the ack low.
- The fastest full cycle, with the device acking immediately, is 6 cycles from cpuIACK to cpuVALID.
- Priority is sampled only in the cycle of cpuIACK. A higher-priority request arriving later waits for the next cycle.

## Configuration
- UBA_TIMEOUT_EN defined:
  - An 8-bit counter runs in VECTRD and clears on entering VECTRD.
  - When it reaches TIMEOUT with no ack: drop devVECTREAD, set cpuVECT=0 and cpuNXM=1, and go directly to DONE, skipping VECTCLR.
- UBA_TIMEOUT_EN undefined:
  - No counter is built.
  - VECTRD and VECTCLR wait indefinitely.
  - cpuNXM is set only by a passive release.

## Structure
- Package uba_intr_pkg holds:
  - the state enum;
  - VECTW=16;
  - the default values of TIMEOUT and HOLDOFF.
- One sub-module, uba_intr_prio: a combinational fixed-priority encoder (lowest index wins) returning the 3-bit index plus an any-request flag.

## Test plan
- Single request, prompt ack:
  - Stimulus: devINTR[2]=1, cpuIACK, device acks with vector 0o340.
  - Required: one-cycle devIACK=0b0100; cpuVECT=0o340, cpuNXM=0, single cpuVALID pulse 6 cycles after cpuIACK.
- Priority:
  - Stimulus: devINTR=0b1010 at cpuIACK.
  - Required: slot 1 selected; devIACK=0b0010; slot 3 is serviced on the next cycle after HOLD.
- Withdrawal:
  - Stimulus: devINTR pulses high for 3 cycles, with no cpuIACK.
  - Required: cpuINTR rises, then falls; state returns to IDLE; no devIACK.
- Passive release:
  - Stimulus: devINTR drops in the same cycle as cpuIACK.
  - Required: cpuVALID with cpuVECT=0, cpuNXM=1; no devIACK.
- Timeout (UBA_TIMEOUT_EN, TIMEOUT=10):
  - Stimulus: no devVECTACK.
  - Required: devVECTREAD drops after 10 cycles; cpuNXM=1, cpuVECT=0.
  - Without the macro: devVECTREAD is still high after 1000 cycles.
- Reset mid-VECTRD:
  - Stimulus: assert rst low.
  - Required: all outputs go to 0 immediately; after rst is released with devINTR still high, cpuINTR=1 one cycle later.
